// File: rtl/cdb_arbiter_pkg.sv
// Shared types and default sizes for the CDB producer-side arbiter.
// The entry tag field is sized by DEF_ROB_DEPTH; a wider ROB needs this package widened too.
package cdb_arbiter_pkg;

  localparam int DEF_N_FU         = 4;
  localparam int DEF_CDB_SIZE     = 3;
  localparam int DEF_ROB_DEPTH    = 4;
  localparam int DEF_FU_BUF_DEPTH = 2;

  typedef struct packed {
    logic [DEF_ROB_DEPTH-1:0] rob;
    logic [31:0]              rd_v;
    logic                     is_branch;
    logic                     branch_take;
    logic [31:0]              branch_pc;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_fu_buffer.sv
// Small per-FU result FIFO of cdb_entry_t; the head is read combinationally for arbitration.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module cdb_fu_buffer
  import cdb_arbiter_pkg::*;
#(
  parameter  int DEPTH = DEF_FU_BUF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  cdb_entry_t       i_wr_data,
  input  logic             i_rd_en,
  output cdb_entry_t       o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  cdb_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_wr    = i_wr_en & ~o_full;
  assign w_rd    = i_rd_en & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus producer: per-FU result FIFOs, round-robin grant onto CDB_SIZE registered lanes,
// at most one branch per cycle. Optional macro CDB_ARB_BYPASS_EN lets an empty FU's live result compete directly.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_FU         = DEF_N_FU,
  parameter int CDB_SIZE     = DEF_CDB_SIZE,
  parameter int ROB_DEPTH    = DEF_ROB_DEPTH,
  parameter int FU_BUF_DEPTH = DEF_FU_BUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 move_flush,
  input  logic [N_FU-1:0]      fu_valid,
  output logic [N_FU-1:0]      fu_ready,
  input  logic [ROB_DEPTH-1:0] fu_rob [N_FU],
  input  logic [31:0]          fu_rd_v [N_FU],
  input  logic [N_FU-1:0]      fu_is_branch,
  input  logic [N_FU-1:0]      fu_branch_take,
  input  logic [31:0]          fu_branch_pc [N_FU],
  output logic [CDB_SIZE-1:0]  cdb_valid,
  output logic [ROB_DEPTH-1:0] cdb_rob [CDB_SIZE],
  output logic [31:0]          cdb_rd_v [CDB_SIZE],
  output logic                 cdb_branch_take,
  output logic [31:0]          cdb_branch_pc
);

  localparam int RR_W   = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam int LANE_W = (CDB_SIZE > 1) ? $clog2(CDB_SIZE) : 1;
  localparam int CNT_W  = $clog2(FU_BUF_DEPTH) + 1;

  logic                 w_flush;
  cdb_entry_t           w_in   [N_FU];
  cdb_entry_t           w_head [N_FU];
  cdb_entry_t           w_cand [N_FU];
  logic [CNT_W-1:0]     w_count [N_FU];
  logic [N_FU-1:0]      w_full;
  logic [N_FU-1:0]      w_empty;
  logic [N_FU-1:0]      w_cand_vld;
  logic [N_FU-1:0]      w_enq;
  logic [N_FU-1:0]      w_deq;
  logic [N_FU-1:0]      w_grant;
  logic [CDB_SIZE-1:0]  w_lane_vld;
  logic [ROB_DEPTH-1:0] w_lane_rob  [CDB_SIZE];
  logic [31:0]          w_lane_rd_v [CDB_SIZE];
  logic                 w_br_take;
  logic [31:0]          w_br_pc;
  logic                 w_any_grant;
  logic [RR_W-1:0]      w_last;
  logic [RR_W-1:0]      w_rr_next;

  logic [RR_W-1:0]      r_rr_ptr;
  logic [CDB_SIZE-1:0]  r_cdb_valid;
  logic [ROB_DEPTH-1:0] r_cdb_rob  [CDB_SIZE];
  logic [31:0]          r_cdb_rd_v [CDB_SIZE];
  logic                 r_br_take;
  logic [31:0]          r_br_pc;

  assign w_flush = rst | move_flush;

  for (genvar gi = 0; gi < N_FU; gi++) begin : g_fu
    assign w_in[gi] = '{rob:         DEF_ROB_DEPTH'(fu_rob[gi]),
                        rd_v:        fu_rd_v[gi],
                        is_branch:   fu_is_branch[gi],
                        branch_take: fu_branch_take[gi],
                        branch_pc:   fu_branch_pc[gi]};
    // Ready comes from the registered count, so a same-cycle dequeue never raises it.
    assign fu_ready[gi] = (w_count[gi] < CNT_W'(FU_BUF_DEPTH));
    assign w_deq[gi]    = w_grant[gi] & ~w_empty[gi];
`ifdef CDB_ARB_BYPASS_EN
    logic w_byp;
    assign w_byp          = w_empty[gi] & fu_valid[gi];
    assign w_cand_vld[gi] = ~w_empty[gi] | w_byp;
    assign w_cand[gi]     = w_empty[gi] ? w_in[gi] : w_head[gi];
    assign w_enq[gi]      = fu_valid[gi] & ~w_full[gi] & ~(w_byp & w_grant[gi]);
`else
    assign w_cand_vld[gi] = ~w_empty[gi];
    assign w_cand[gi]     = w_head[gi];
    assign w_enq[gi]      = fu_valid[gi] & ~w_full[gi];
`endif

    cdb_fu_buffer #(
      .DEPTH(FU_BUF_DEPTH)
    ) u_buf (
      .clk      (clk),
      .rst      (w_flush),
      .i_wr_en  (w_enq[gi]),
      .i_wr_data(w_in[gi]),
      .i_rd_en  (w_deq[gi]),
      .o_head   (w_head[gi]),
      .o_count  (w_count[gi]),
      .o_full   (w_full[gi]),
      .o_empty  (w_empty[gi])
    );
  end

  // Round-robin scan from r_rr_ptr; a second branch head is skipped but later non-branch heads still compete.
  always_comb begin
    int  n_lane;
    int  idx;
    logic br_done;
    w_grant     = '0;
    w_lane_vld  = '0;
    w_br_take   = 1'b0;
    w_br_pc     = '0;
    w_any_grant = 1'b0;
    w_last      = r_rr_ptr;
    n_lane      = 0;
    idx         = 0;
    br_done     = 1'b0;
    for (int k = 0; k < CDB_SIZE; k++) begin
      w_lane_rob[k]  = '0;
      w_lane_rd_v[k] = '0;
    end
    for (int j = 0; j < N_FU; j++) begin
      idx = (int'(r_rr_ptr) + j) % N_FU;
      if (w_cand_vld[RR_W'(idx)] && (n_lane < CDB_SIZE) &&
          !(w_cand[RR_W'(idx)].is_branch && br_done)) begin
        w_grant[RR_W'(idx)]          = 1'b1;
        w_lane_vld[LANE_W'(n_lane)]  = 1'b1;
        w_lane_rob[LANE_W'(n_lane)]  = ROB_DEPTH'(w_cand[RR_W'(idx)].rob);
        w_lane_rd_v[LANE_W'(n_lane)] = w_cand[RR_W'(idx)].rd_v;
        if (w_cand[RR_W'(idx)].is_branch) begin
          br_done   = 1'b1;
          w_br_take = w_cand[RR_W'(idx)].branch_take;
          w_br_pc   = w_cand[RR_W'(idx)].branch_pc;
        end
        n_lane      = n_lane + 1;
        w_last      = RR_W'(idx);
        w_any_grant = 1'b1;
      end
    end
  end

  assign w_rr_next = (w_last == RR_W'(N_FU - 1)) ? '0 : w_last + RR_W'(1);

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= '0;
      r_br_take   <= 1'b0;
      r_br_pc     <= '0;
      for (int k = 0; k < CDB_SIZE; k++) begin
        r_cdb_rob[k]  <= '0;
        r_cdb_rd_v[k] <= '0;
      end
    end else begin
      if (w_any_grant) begin
        r_rr_ptr <= w_rr_next;
      end
      r_cdb_valid <= w_lane_vld;
      r_br_take   <= w_br_take;
      r_br_pc     <= w_br_pc;
      for (int k = 0; k < CDB_SIZE; k++) begin
        r_cdb_rob[k]  <= w_lane_rob[k];
        r_cdb_rd_v[k] <= w_lane_rd_v[k];
      end
    end
  end

  assign cdb_valid       = r_cdb_valid;
  assign cdb_rob         = r_cdb_rob;
  assign cdb_rd_v        = r_cdb_rd_v;
  assign cdb_branch_take = r_br_take;
  assign cdb_branch_pc   = r_br_pc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table for arbitration/flush/reset, hand sequences for latency and backpressure.
module tb_cdb_arbiter;

  localparam int NF = 4;
  localparam int NC = 3;
`ifdef CDB_ARB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        move_flush;
  logic [3:0]  fu_valid;
  logic [3:0]  fu_ready;
  logic [3:0]  fu_rob [NF];
  logic [31:0] fu_rd_v [NF];
  logic [3:0]  fu_is_branch;
  logic [3:0]  fu_branch_take;
  logic [31:0] fu_branch_pc [NF];
  logic [2:0]  cdb_valid;
  logic [3:0]  cdb_rob [NC];
  logic [31:0] cdb_rd_v [NC];
  logic        cdb_branch_take;
  logic [31:0] cdb_branch_pc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .move_flush     (move_flush),
    .fu_valid       (fu_valid),
    .fu_ready       (fu_ready),
    .fu_rob         (fu_rob),
    .fu_rd_v        (fu_rd_v),
    .fu_is_branch   (fu_is_branch),
    .fu_branch_take (fu_branch_take),
    .fu_branch_pc   (fu_branch_pc),
    .cdb_valid      (cdb_valid),
    .cdb_rob        (cdb_rob),
    .cdb_rd_v       (cdb_rd_v),
    .cdb_branch_take(cdb_branch_take),
    .cdb_branch_pc  (cdb_branch_pc)
  );

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic [3:0]  v;
    logic [3:0]  br;
    logic [15:0] robs;   // FU i tag at [4i+:4]
    logic [2:0]  ev;
    logic [11:0] erob;   // lane k tag at [4k+:4]
    logic        etake;
    logic [31:0] epc;
    logic [3:0]  erdy;
  } row_t;

  localparam int NROWS = 41;
  row_t tbl [NROWS];

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic row_t mk(logic r, logic f, logic [3:0] v, logic [3:0] br, logic [15:0] robs,
                              logic [2:0] ev, logic [11:0] erob, logic etake, logic [31:0] epc);
    return '{rst: r, flush: f, v: v, br: br, robs: robs, ev: ev, erob: erob,
             etake: etake, epc: epc, erdy: 4'hF};
  endfunction

  function automatic logic [31:0] val_of(logic [3:0] rob);
    return 32'hC0DE_0000 | {28'h0, rob};
  endfunction

  task automatic drive_idle();
    fu_valid       = '0;
    fu_is_branch   = '0;
    fu_branch_take = '0;
    for (int i = 0; i < NF; i++) begin
      fu_rob[i]       = '0;
      fu_rd_v[i]      = '0;
      fu_branch_pc[i] = '0;
    end
  endtask

  // Non-branch results carry take=1 and a junk PC that must never reach the branch outputs.
  task automatic drive_fu(int i, logic [3:0] rob, logic br);
    fu_valid[i]       = 1'b1;
    fu_rob[i]         = rob;
    fu_rd_v[i]        = val_of(rob);
    fu_is_branch[i]   = br;
    fu_branch_take[i] = 1'b1;
    fu_branch_pc[i]   = {20'h0, rob, 8'h00} + (br ? 32'h0 : 32'h0BAD_0000);
  endtask

  function automatic logic [11:0] lanes_rob();
    return {cdb_rob[2], cdb_rob[1], cdb_rob[0]};
  endfunction

  function automatic logic [95:0] lanes_rdv();
    return {cdb_rd_v[2], cdb_rd_v[1], cdb_rd_v[0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    move_flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int          seen;
  int          acc;
  logic        prev_rdy3;
  logic [3:0]  got [$];
  logic [95:0] exp_rdv;

  initial begin
    rst = 1'b1;
    move_flush = 1'b0;
    drive_idle();

    // Oversubscription, branch limit, rr wrap, flush and reset, one row per cycle.
    tbl[0]  = mk(0, 0, 4'hF, 4'h0, 16'h3210, 3'b000, 12'h000, 0, 32'h0);
    tbl[1]  = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[2]  = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b111, 12'h210, 0, 32'h0);
    tbl[3]  = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b001, 12'h003, 0, 32'h0);
    tbl[4]  = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[5]  = mk(0, 0, 4'h7, 4'h5, 16'h0241, 3'b000, 12'h000, 0, 32'h0);
    tbl[6]  = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[7]  = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b011, 12'h041, 1, 32'h100);
    tbl[8]  = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b001, 12'h002, 1, 32'h200);
    tbl[9]  = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[10] = mk(0, 0, 4'hF, 4'h0, 16'h8765, 3'b000, 12'h000, 0, 32'h0);
    tbl[11] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[12] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b111, 12'h658, 0, 32'h0);
    tbl[13] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b001, 12'h007, 0, 32'h0);
    tbl[14] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[15] = mk(0, 0, 4'h2, 4'h0, 16'h0090, 3'b000, 12'h000, 0, 32'h0);
    tbl[16] = mk(0, 1, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[17] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[18] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[19] = mk(0, 0, 4'h1, 4'h0, 16'h0003, 3'b000, 12'h000, 0, 32'h0);
    tbl[20] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[21] = mk(0, 1, 4'h0, 4'h0, 16'h0000, 3'b001, 12'h003, 0, 32'h0);
    tbl[22] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[23] = mk(0, 0, 4'hF, 4'h0, 16'h4321, 3'b000, 12'h000, 0, 32'h0);
    tbl[24] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[25] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b111, 12'h321, 0, 32'h0);
    tbl[26] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b001, 12'h004, 0, 32'h0);
    tbl[27] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[28] = mk(0, 1, 4'hF, 4'h0, 16'h8765, 3'b000, 12'h000, 0, 32'h0);
    tbl[29] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[30] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[31] = mk(0, 0, 4'hF, 4'h0, 16'h4321, 3'b000, 12'h000, 0, 32'h0);
    tbl[32] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[33] = mk(1, 0, 4'h0, 4'h0, 16'h0000, 3'b111, 12'h321, 0, 32'h0);
    tbl[34] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[35] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[36] = mk(0, 0, 4'hF, 4'h0, 16'h8765, 3'b000, 12'h000, 0, 32'h0);
    tbl[37] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);
    tbl[38] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b111, 12'h765, 0, 32'h0);
    tbl[39] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b001, 12'h008, 0, 32'h0);
    tbl[40] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 3'b000, 12'h000, 0, 32'h0);

    // Reset state
    do_reset();
    check("reset_valid", 128'(cdb_valid), 128'(3'b000));
    check("reset_lanes", 128'({lanes_rob(), lanes_rdv()}), 128'(0));
    check("reset_branch", 128'({cdb_branch_take, cdb_branch_pc}), 128'(0));
    check("reset_ready", 128'(fu_ready), 128'(4'hF));

    // Single result from FU1
    drive_fu(1, 4'd5, 1'b0);
    fu_rd_v[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    drive_idle();
    seen = 0;
    for (int c = 1; c <= 8 && seen == 0; c++) begin
      if (cdb_valid != 3'b000) seen = c;
      else @(negedge clk);
    end
    check("single_latency", 128'(seen), 128'(LAT));
    check("single_valid", 128'(cdb_valid), 128'(3'b001));
    check("single_rob", 128'(lanes_rob()), 128'(12'h005));
    check("single_rdv", 128'(lanes_rdv()), 128'({32'h0, 32'h0, 32'hDEAD_BEEF}));
    check("single_branch", 128'({cdb_branch_take, cdb_branch_pc}), 128'(0));
    @(negedge clk);
    check("single_one_cycle", 128'(cdb_valid), 128'(3'b000));

    // Backpressure: FU3 presents A,B,C (rob 10..12) with hold-until-ready while FU0-2 saturate lanes
    do_reset();
    acc = 0;
    prev_rdy3 = 1'b0;
    got.delete();
    for (int c = 0; c < 24; c++) begin
      for (int k = 0; k < NC; k++) begin
        if (cdb_valid[k] && cdb_rob[k] >= 4'd10) begin
          got.push_back(cdb_rob[k]);
          check($sformatf("bp_rdv_%0d", cdb_rob[k]), 128'(cdb_rd_v[k]), 128'(val_of(cdb_rob[k])));
        end
      end
      if (c > 0 && fu_valid[3] && prev_rdy3) acc++;
      if (c == 2) check("bp_ready_low", 128'(fu_ready[3]), 128'(1'b0));
      drive_idle();
      if (c < 3) begin
        for (int i = 0; i < 3; i++) drive_fu(i, 4'(i), 1'b0);
      end
      if (acc < 3) drive_fu(3, 4'(10 + acc), 1'b0);
      prev_rdy3 = fu_ready[3];
      @(negedge clk);
    end
    drive_idle();
    check("bp_accepts", 128'(acc), 128'(3));
    check("bp_count", 128'(got.size()), 128'(3));
    if (got.size() == 3)
      check("bp_order", 128'({got[0], got[1], got[2]}), 128'({4'd10, 4'd11, 4'd12}));

`ifndef CDB_ARB_BYPASS_EN
    do_reset();
    for (int r = 0; r < NROWS; r++) begin
      check($sformatf("r%0d_valid", r), 128'(cdb_valid), 128'(tbl[r].ev));
      check($sformatf("r%0d_rob", r), 128'(lanes_rob()), 128'(tbl[r].erob));
      exp_rdv = '0;
      for (int k = 0; k < NC; k++)
        if (tbl[r].ev[k]) exp_rdv[32*k +: 32] = val_of(tbl[r].erob[4*k +: 4]);
      check($sformatf("r%0d_rdv", r), 128'(lanes_rdv()), 128'(exp_rdv));
      check($sformatf("r%0d_branch", r), 128'({cdb_branch_take, cdb_branch_pc}),
            128'({tbl[r].etake, tbl[r].epc}));
      check($sformatf("r%0d_ready", r), 128'(fu_ready), 128'(tbl[r].erdy));
      drive_idle();
      rst        = tbl[r].rst;
      move_flush = tbl[r].flush;
      for (int i = 0; i < NF; i++)
        if (tbl[r].v[i]) drive_fu(i, tbl[r].robs[4*i +: 4], tbl[r].br[i]);
      @(negedge clk);
    end
    rst = 1'b0;
    move_flush = 1'b0;
    drive_idle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
